sdram_port_arbiter: RTL and testbench

Shares one sdram_controller host interface among NUM_PORTS requesters. Sits between the client masters and the controller's rd_req/wr_req/in_addr/wr_data/bank_addr inputs. It consumes the controller's rd_gnt/wr_gnt/rd_data_valid/rd_data outputs.
Round-robin arbitration, one outstanding transaction at a time, read data routed back to the owning port, with a read-return timeout.

---
 rtl/sdram_arb_pkg.sv | 12 +
 rtl/sdram_port_arbiter_rr_pick.sv | 27 ++
 rtl/sdram_port_arbiter.sv | 117 +++++++++++
 tb/tb_sdram_port_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding and default widths for the sdram port arbiter
package sdram_arb_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RECOVER = 2'd3
  } state_t;
  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 8;
  localparam int BANK_W = 2;
endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first request at or after ptr wrapping modulo N
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);
  logic [IW-1:0] k;
  // scan offsets 0..N-1 from ptr, first hit wins
  always_comb begin
    k = '0;
    idx = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(ptr) + i) % N);
      if (!valid && req[k]) begin
        valid = 1'b1;
        idx = k;
      end
    end
    gnt = valid ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one sdram_controller host port among NUM_PORTS requesters,
// one transaction at a time, with read-return timeout. Define PORT0_PRIORITY_EN to make
// port 0 strict highest priority with ports 1..NUM_PORTS-1 round-robin among themselves.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        p_req,
  input  logic [NUM_PORTS-1:0]        p_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] p_addr,
  input  logic [NUM_PORTS*BANK_W-1:0] p_bank,
  input  logic [NUM_PORTS*DATA_W-1:0] p_wdata,
  output logic [NUM_PORTS-1:0]        p_gnt,
  output logic [DATA_W-1:0]           p_rdata,
  output logic [NUM_PORTS-1:0]        p_rvalid,
  output logic                        rd_timeout,
  output logic                        rd_req,
  output logic                        wr_req,
  output logic [ADDR_W-1:0]           in_addr,
  output logic [DATA_W-1:0]           wr_data,
  output logic [BANK_W-1:0]           bank_addr,
  input  logic                        rd_gnt,
  input  logic                        wr_gnt,
  input  logic                        rd_data_valid,
  input  logic [DATA_W-1:0]           rd_data
);
  localparam int IW = $clog2(NUM_PORTS);
  state_t state, nxt;
  logic [IW-1:0] rr_ptr, owner, pk_idx, sel_idx, inc_ptr, nxt_ptr;
  logic [NUM_PORTS-1:0] pk_req, pk_gnt;
  logic [7:0] cnt;
  logic pk_valid, any, sel_we, we_r, granted, timeout_hit;
  rr_pick #(.N(NUM_PORTS), .IW(IW)) u_pick (
    .req(pk_req), .ptr(rr_ptr), .gnt(pk_gnt), .idx(pk_idx), .valid(pk_valid)
  );
  assign inc_ptr = (owner == IW'(NUM_PORTS - 1)) ? '0 : owner + 1'b1;
`ifdef PORT0_PRIORITY_EN
  localparam logic [IW-1:0] PTR_RST = IW'(1);
  assign pk_req = p_req & ~NUM_PORTS'(1);
  assign any = p_req[0] | pk_valid;
  assign sel_idx = p_req[0] ? '0 : pk_idx;
  assign sel_we = p_req[0] ? p_we[0] : |(p_we & pk_gnt);
  assign nxt_ptr = (inc_ptr == '0) ? IW'(1) : inc_ptr;
`else
  localparam logic [IW-1:0] PTR_RST = '0;
  assign pk_req = p_req;
  assign any = pk_valid;
  assign sel_idx = pk_idx;
  assign sel_we = |(p_we & pk_gnt);
  assign nxt_ptr = inc_ptr;
`endif
  assign granted = (state == ISSUE) && (we_r ? wr_gnt : rd_gnt);
  assign timeout_hit = (state == WAIT_RD) && !rd_data_valid && (cnt == 8'(RD_TIMEOUT - 1));
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  end
  // next-state: arbitrate, wait for grant, wait for read data, one recovery bubble
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = any ? ISSUE : IDLE;
      ISSUE:   nxt = granted ? (we_r ? RECOVER : WAIT_RD) : ISSUE;
      WAIT_RD: nxt = (rd_data_valid || timeout_hit) ? RECOVER : WAIT_RD;
      RECOVER: nxt = IDLE;
    endcase
  end
  // controller requests are held for the whole ISSUE state only
  always_comb begin
    rd_req = (state == ISSUE) && !we_r;
    wr_req = (state == ISSUE) && we_r;
  end
  // latched request fields, round-robin pointer, wait counter and one-cycle port pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= PTR_RST;
      owner <= '0;
      we_r <= 1'b0;
      in_addr <= '0;
      bank_addr <= '0;
      wr_data <= '0;
      cnt <= '0;
      p_gnt <= '0;
      p_rvalid <= '0;
      p_rdata <= '0;
      rd_timeout <= 1'b0;
    end else begin
      p_gnt <= '0;
      p_rvalid <= '0;
      rd_timeout <= 1'b0;
      cnt <= (state == WAIT_RD) ? cnt + 8'd1 : '0;
      if (state == IDLE && any) begin
        owner <= sel_idx;
        we_r <= sel_we;
        in_addr <= p_addr[sel_idx*ADDR_W +: ADDR_W];
        bank_addr <= p_bank[sel_idx*BANK_W +: BANK_W];
        wr_data <= p_wdata[sel_idx*DATA_W +: DATA_W];
      end
      if (granted) begin
        p_gnt <= NUM_PORTS'(1) << owner;
        rr_ptr <= nxt_ptr;
      end
      if (state == WAIT_RD && rd_data_valid) begin
        p_rdata <= rd_data;
        p_rvalid <= NUM_PORTS'(1) << owner;
      end
      if (timeout_hit) rd_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed + randomized checks of sdram_port_arbiter against a transaction-level model
module tb_sdram_port_arbiter;
  localparam int N = 4, AW = 24, DW = 8, TO = 255;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [N-1:0] p_req = '0, p_we = '0, p_gnt, p_rvalid;
  logic [N*AW-1:0] p_addr = '0;
  logic [N*2-1:0] p_bank = '0;
  logic [N*DW-1:0] p_wdata = '0;
  logic [DW-1:0] p_rdata, wr_data, rd_data = '0;
  logic [AW-1:0] in_addr;
  logic [1:0] bank_addr;
  logic rd_timeout, rd_req, wr_req;
  logic rd_gnt = 1'b0, wr_gnt = 1'b0, rd_data_valid = 1'b0;
  int tests = 0, fails = 0;
  bit auto_ctl = 0, auto_ports = 0;

  sdram_port_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_bank(p_bank),
    .p_wdata(p_wdata), .p_gnt(p_gnt), .p_rdata(p_rdata), .p_rvalid(p_rvalid), .rd_timeout(rd_timeout),
    .rd_req(rd_req), .wr_req(wr_req), .in_addr(in_addr), .wr_data(wr_data), .bank_addr(bank_addr),
    .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .rd_data_valid(rd_data_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: one open transaction at a time, tracked as a record with an age
  bit m_busy, m_req, m_rd, m_we;
  int m_own, m_ptr, m_age;
  logic [AW-1:0] e_addr;
  logic [1:0] e_bank;
  logic [DW-1:0] e_wd, e_rdata;
  logic [N-1:0] e_gnt, e_rv;
  logic e_to;

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    logic [N-1:0] q = r;
`ifdef PORT0_PRIORITY_EN
    if (q[0]) return 0;
    q[0] = 1'b0;
`endif
    for (int i = 0; i < N; i++) if (q[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  function automatic int after(input int own);
`ifdef PORT0_PRIORITY_EN
    return ((own + 1) % N == 0) ? 1 : (own + 1) % N;
`else
    return (own + 1) % N;
`endif
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_req = 0; m_rd = 0; m_we = 0; m_own = 0; m_age = 0;
`ifdef PORT0_PRIORITY_EN
      m_ptr = 1;
`else
      m_ptr = 0;
`endif
      e_addr = '0; e_bank = '0; e_wd = '0; e_rdata = '0; e_gnt = '0; e_rv = '0; e_to = 0;
    end else begin
      e_gnt = '0; e_rv = '0; e_to = 0;
      if (!m_busy) begin
        if (|p_req) begin
          m_own = pick(p_req, m_ptr);
          m_busy = 1; m_req = 1; m_we = p_we[m_own];
          e_addr = p_addr[m_own*AW +: AW]; e_bank = p_bank[m_own*2 +: 2]; e_wd = p_wdata[m_own*DW +: DW];
        end
      end else if (m_req) begin
        if (m_we ? wr_gnt : rd_gnt) begin
          m_req = 0; e_gnt[m_own] = 1'b1; m_ptr = after(m_own);
          m_rd = !m_we; m_age = 0;
        end
      end else if (m_rd) begin
        m_age++;
        if (rd_data_valid) begin e_rv[m_own] = 1'b1; e_rdata = rd_data; m_rd = 0; end
        else if (m_age == TO) begin e_to = 1; m_rd = 0; end
      end else m_busy = 0;
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) if (reset_n) begin
    chk("ctrl", {rd_req, wr_req, bank_addr, in_addr, wr_data}, {m_req && !m_we, m_req && m_we, e_bank, e_addr, e_wd});
    chk("pulse", {p_gnt, p_rvalid, rd_timeout}, {e_gnt, e_rv, e_to});
    chk("rdata", p_rdata, e_rdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_ctl) begin
      rd_gnt = rd_req ? ($urandom % 3 == 0) : ($urandom % 10 == 0);
      wr_gnt = wr_req ? ($urandom % 3 == 0) : ($urandom % 10 == 0);
      rd_data_valid = ($urandom % 5 == 0);
      rd_data = DW'($urandom);
    end
    if (auto_ports)
      for (int i = 0; i < N; i++)
        if (p_gnt[i]) p_req[i] = 1'b0;
        else if (!p_req[i] && $urandom % 4 == 0) begin
          p_req[i] = 1'b1; p_we[i] = 1'($urandom);
          p_addr[i*AW +: AW] = AW'($urandom); p_bank[i*2 +: 2] = 2'($urandom);
          p_wdata[i*DW +: DW] = DW'($urandom);
        end
  endtask

  task automatic req_port(input int i, input bit we, input logic [AW-1:0] a, input logic [1:0] b, input logic [DW-1:0] d);
    p_req[i] = 1'b1; p_we[i] = we; p_addr[i*AW +: AW] = a; p_bank[i*2 +: 2] = b; p_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    int k, n;
    bit seen;
    int order[5];
    int exp_order[5];
`ifdef PORT0_PRIORITY_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("reset_outputs", {rd_req, wr_req, p_gnt, p_rvalid, rd_timeout, in_addr, p_rdata}, '0);

    req_port(2, 1, 24'h123456, 2'b01, 8'h55);
    tick();
    chk("wr_issue", {wr_req, rd_req, in_addr, wr_data, bank_addr}, {2'b10, 24'h123456, 8'h55, 2'b01});
    tick(); tick();
    chk("wr_hold", wr_req, 1'b1);
    wr_gnt = 1'b1;
    tick();
    chk("wr_pgnt", {p_gnt, wr_req}, {4'b0100, 1'b0});
    wr_gnt = 1'b0; p_req = '0;
    tick();
    chk("wr_pgnt_pulse", p_gnt, 4'b0000);

    req_port(1, 0, 24'h789ABC, 2'b10, 8'h00);
    tick();
    chk("rd_issue", {rd_req, in_addr, bank_addr}, {1'b1, 24'h789ABC, 2'b10});
    rd_gnt = 1'b1;
    tick();
    chk("rd_pgnt", {p_gnt, rd_req}, {4'b0010, 1'b0});
    rd_gnt = 1'b0; p_req = '0;
    repeat (3) tick();
    rd_data_valid = 1'b1; rd_data = 8'hDE;
    tick();
    chk("rd_rvalid", {p_rvalid, p_rdata}, {4'b0010, 8'hDE});
    rd_data_valid = 1'b0; rd_data = 8'h00;
    tick();
    chk("rd_hold", {p_rvalid, p_rdata}, {4'b0000, 8'hDE});

    req_port(3, 0, 24'h00C0DE, 2'b00, 8'h00);
    tick();
    req_port(0, 0, 24'h000ABC, 2'b01, 8'h00);
    rd_gnt = 1'b1;
    tick();
    rd_gnt = 1'b0; p_req[3] = 1'b0;
    k = 0; seen = 0;
    do begin
      tick(); k++;
      if (p_rvalid != '0) seen = 1;
    end while (!rd_timeout && k < 400);
    chk("timeout_cycle", k, TO);
    chk("timeout_no_rvalid", seen, 0);
    tick();
    chk("recover_idle", rd_req, 1'b0);
    tick();
    chk("next_issue", {rd_req, in_addr}, {1'b1, 24'h000ABC});
    rd_gnt = 1'b1;
    tick();
    rd_gnt = 1'b0; p_req = '0; rd_data_valid = 1'b1; rd_data = 8'h3C;
    tick();
    rd_data_valid = 1'b0;
    tick(); tick();

    req_port(3, 0, 24'h0F0F0F, 2'b11, 8'h00);
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("refresh_stall", {rd_req, in_addr, bank_addr, rd_timeout}, {1'b1, 24'h0F0F0F, 2'b11, 1'b0});
    end
    rd_gnt = 1'b1;
    tick();
    rd_gnt = 1'b0; p_req = '0; rd_data_valid = 1'b1; rd_data = 8'hA5;
    tick();
    chk("refresh_rvalid", {p_rvalid, p_rdata}, {4'b1000, 8'hA5});
    rd_data_valid = 1'b0;
    tick(); tick();

    req_port(0, 0, 24'h111111, 2'b00, 8'h00);
    tick();
    chk("pre_reset_req", rd_req, 1'b1);
    #1 reset_n = 1'b0;
    #1 chk("async_drop", {rd_req, wr_req}, 2'b00);
    p_req = '0;
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_gnt_after_reset", {p_gnt, rd_req}, '0);
    end

    auto_ctl = 1; p_we = '0; p_req = '1;
    n = 0; k = 0;
    while (n < 5 && k < 500) begin
      tick(); k++;
      if (p_gnt != '0) begin
        for (int i = 0; i < N; i++) if (p_gnt[i]) order[n] = i;
        n++;
      end
    end
    chk("rr_count", n, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);
    p_req = '0;

    auto_ports = 1;
    repeat (4000) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
